// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_pkg;

  localparam int unsigned      XLEN         = 32;
  localparam logic [XLEN-1:0]  RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned      PC_STEP_DEF  = 4;
  localparam int unsigned      FETCH_DEPTH  = 2;

  // S_DROP: a request issued before a redirect is still in flight; its data is stale
  typedef enum logic {
    S_REQ  = 1'b0,
    S_DROP = 1'b1
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {instruction, pc} pairs; head is presented directly.
// Latency: an entry pushed on cycle t is visible at the head on cycle t+1.
// Backpressure: caller must not push when full unless popping the same cycle; flush wins.
module fetch_fifo #(
  parameter  int unsigned N     = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [N-1:0]  push_instr,
  input  logic [N-1:0]  push_pc,
  output logic [N-1:0]  head_instr,
  output logic [N-1:0]  head_pc,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [N-1:0]  instr_mem [DEPTH];
  logic [N-1:0]  pc_mem    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; cleared on reset so the head reads zero until the first fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (do_push && !flush) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetches over req/ack, buffers up to two words for decode.
// Latency: word acked in cycle t is presented on cycle t+1; redirect target no earlier than t+2.
// Backpressure: stall holds the head; new requests stop once the buffer would be full.
module if_stage import if_pkg::*; #(
  parameter int unsigned   N        = XLEN,
  parameter logic [N-1:0]  RESET_PC = RESET_PC_DEF,
  parameter int unsigned   PC_STEP  = PC_STEP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] instruction,
  output logic [N-1:0] pc_out,
  output logic         valid
);

  localparam int unsigned CW = $clog2(FETCH_DEPTH + 1);

  if_state_t     state;
  if_state_t     state_nxt;
  logic [N-1:0]  pc;
  logic [N-1:0]  pc_nxt;
  logic [N-1:0]  req_addr;
  logic          req_q;
  logic          req_nxt;
  logic          issue;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  logic [N-1:0]  head_instr;
  logic [N-1:0]  head_pc;

  assign imem_req    = req_q;
  assign imem_addr   = req_addr;
  assign valid       = !fifo_empty;
  assign instruction = head_instr;
  assign pc_out      = head_pc;
  assign pop         = valid && !stall;
  // Only a response to a request of the current stream is kept, and never alongside a redirect
  assign push        = req_q && imem_ack && (state == S_REQ) && !redirect;

  // Next PC, FSM transition, and whether a new request starts at this edge
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    req_nxt     = req_q;
    count_after = fifo_count;
    issue       = 1'b0;

    if (redirect)  pc_nxt = redirect_pc;
    else if (push) pc_nxt = pc + N'(PC_STEP);

    case (state)
      S_REQ:   if (redirect && req_q && !imem_ack) state_nxt = S_DROP;
      S_DROP:  if (req_q && imem_ack)              state_nxt = S_REQ;
      default:                                     state_nxt = S_REQ;
    endcase

    if (redirect) count_after = '0;
    else          count_after = fifo_count + CW'(push) - CW'(pop);

    if (req_q && imem_ack) req_nxt = 1'b0;
    // A new request needs the bus free and a buffer slot guaranteed for its response
    issue = (!req_q || imem_ack) && (count_after < CW'(FETCH_DEPTH));
    if (issue) req_nxt = 1'b1;
  end

  // PC, request and FSM state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      req_q <= req_nxt;
      if (issue) req_addr <= pc_nxt;
    end
  end

  fetch_fifo #(
    .N     (N),
    .DEPTH (FETCH_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_instr (imem_rdata),
    .push_pc    (req_addr),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  a_gated_push: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized stall/redirect/latency/reset.
// Latency: n/a.
// Backpressure: stall driven randomly; memory latency 0..3 cycles.
module tb_if_stage;
  import if_pkg::*;

  localparam int unsigned N = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [N-1:0] redirect_pc = '0;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [N-1:0] imem_rdata;
  logic [N-1:0] instruction;
  logic [N-1:0] pc_out;
  logic         valid;

  int checks = 0;
  int errors = 0;

  if_stage #(.N(N), .RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_out      (pc_out),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  // Memory: content is a fixed function of the address; ack after lat waiting cycles
  int unsigned lat = 0;
  int unsigned wait_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge reset) begin
    if (!reset)                    wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference stream: consecutive PCs from the latest start point, instruction = memory word
  fetch_entry_t exp_q[$];
  logic [31:0]  gen_pc = '0;

  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{instr: mem_word(gen_pc), pc: gen_pc});
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] t);
    exp_q.delete();
    gen_pc = t;
    refill();
  endfunction

  // Monitor: compares each instruction decode accepts, plus handshake/hold properties
  int           acc_cnt = 0;
  logic         prev_ok = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
  logic         prev_redirect = 1'b0, prev_hold = 1'b0;
  logic [31:0]  prev_addr = '0, prev_pc = '0, prev_instr = '0;
  fetch_entry_t e;

  always @(negedge clk) begin
    if (reset && prev_ok) begin
      if (prev_req && !prev_ack)
        check("addr_hold", imem_req && (imem_addr == prev_addr), imem_addr, prev_addr);
      if (prev_redirect)
        check("valid_after_redirect", !valid, {31'd0, valid}, 32'd0);
      if (prev_hold) begin
        check("stall_hold_pc", valid && (pc_out == prev_pc), pc_out, prev_pc);
        check("stall_hold_instr", instruction == prev_instr, instruction, prev_instr);
      end
    end
    if (reset && valid && !stall && !redirect) begin
      e = exp_q.pop_front();
      refill();
      check("stream_pc", pc_out == e.pc, pc_out, e.pc);
      check("stream_instr", instruction == e.instr, instruction, e.instr);
      acc_cnt++;
    end
    prev_ok       = reset;
    prev_req      = imem_req;
    prev_ack      = imem_ack;
    prev_addr     = imem_addr;
    prev_redirect = redirect;
    prev_hold     = valid && stall && !redirect;
    prev_pc       = pc_out;
    prev_instr    = instruction;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    restart(t);
    tick();
    redirect    = 1'b0;
  endtask

  // Wait (bounded) for an outstanding, not-yet-acked request or for an ack
  task automatic wait_req(input logic want_ack, input logic fresh, input string name);
    int n = 0;
    while (!(imem_req && (imem_ack == want_ack) && (!fresh || wait_cnt == 0)) && n < 50) begin
      tick();
      n++;
    end
    check(name, n < 50, n, 50);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req == 1'b0, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"},  imem_addr == RST_PC, imem_addr, RST_PC);
    check({tag, "_valid"}, valid == 1'b0, {31'd0, valid}, 32'd0);
    check({tag, "_instr"}, instruction == '0, instruction, 32'd0);
    check({tag, "_pc"},    pc_out == '0, pc_out, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int a0;
    logic [31:0] t;
    int r;

    restart(RST_PC);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Zero-latency, no stall: valid from the second cycle after release onward
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid) nv++;
    end
    check("startup_valid_cycles", nv == 18, nv, 18);
    tick();

    // Five-cycle stall: buffer fills, requests stop, head frozen
    stall = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("stall_full_req", imem_req == 1'b0, {31'd0, imem_req}, 32'd0);
    check("stall_full_valid", valid == 1'b1, {31'd0, valid}, 32'd1);
    tick();
    stall = 1'b0;
    repeat (6) tick();

    // Latency 3: one instruction every four cycles
    lat = 3;
    repeat (16) tick();
    a0 = acc_cnt;
    repeat (24) tick();
    check("lat3_rate", (acc_cnt - a0) == 6, acc_cnt - a0, 6);

    // Redirect with a request outstanding: stale ack discarded
    wait_req(1'b0, 1'b0, "wait_outstanding");
    a0 = acc_cnt;
    apply_redirect(32'h0000_0100);
    repeat (20) tick();
    check("redirect_progress", (acc_cnt - a0) >= 3, acc_cnt - a0, 3);

    // Redirect together with an ack
    lat = 2;
    wait_req(1'b1, 1'b0, "wait_ack");
    apply_redirect(32'h0000_0200);
    repeat (10) tick();

    // Two redirects while the stale request is still in flight
    lat = 3;
    wait_req(1'b0, 1'b1, "wait_fresh");
    apply_redirect(32'h0000_0300);
    a0 = acc_cnt;
    apply_redirect(32'h0000_0400);
    repeat (20) tick();
    check("double_redirect_progress", (acc_cnt - a0) >= 2, acc_cnt - a0, 2);

    // Reset in the middle of a request
    wait_req(1'b0, 1'b1, "wait_mid");
    tick();
    reset = 1'b0;
    restart(RST_PC);
    #1;
    check_reset_outputs("midreset");
    tick();
    tick();
    lat   = 0;
    reset = 1'b1;
    a0    = acc_cnt;
    repeat (10) tick();
    check("restart_progress", (acc_cnt - a0) >= 7, acc_cnt - a0, 7);

    // PC wrap through the top of the address space
    apply_redirect(32'hFFFF_FFF0);
    a0 = acc_cnt;
    repeat (12) tick();
    check("wrap_progress", (acc_cnt - a0) >= 8, acc_cnt - a0, 8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) lat = $urandom_range(0, 3);
      stall = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 999);
      if (r < 3) begin
        reset = 1'b0;
        restart(RST_PC);
        tick();
        reset = 1'b1;
      end else if (r < 40) begin
        if ($urandom_range(0, 1) == 1) t = $urandom & 32'hFFFF_FFFC;
        else                           t = 32'hFFFF_FFE0 + ($urandom_range(0, 7) << 2);
        apply_redirect(t);
      end else begin
        tick();
      end
    end
    stall = 1'b0;
    repeat (20) tick();
    check("total_progress", acc_cnt > 300, acc_cnt, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
